// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Optional timeout releases an owner that stalls between bytes of a packet.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no owner; round-robin search from last_g+1, winner's byte taken
//   ST_SEND  | held byte presented to uart_tx until i_tx_ready
//   ST_GAP   | one dead cycle while uart_tx drops o_ready; release on last
//   ST_FETCH | wait for owner's next byte, timeout counter running
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ*8-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [N_REQ-1:0]   i_req_last,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_timeout
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FETCH} state_t;

   state_t          state;
   logic [IW-1:0]   last_g;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   win;
   logic [IW-1:0]   idx;
   logic            found;
   logic            held_last;
   logic [TW-1:0]   to_cnt;
   logic [TW-1:0]   to_cnt_inc;
   logic [7:0]      req_byte [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
      assign req_byte[g] = i_req_data[8*g +: 8];
   end

   always_comb begin
      found = 1'b0;
      win   = last_g;
      idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = IW'((int'(last_g) + i) % N_REQ);
         if (!found && i_req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Ready is gated by reset so nothing is consumed that reset would then discard.
   always_comb begin
      o_req_ready = '0;
      if (i_rst) begin
         if (state == ST_IDLE && found)
            o_req_ready[win] = 1'b1;
         else if (state == ST_FETCH && i_req_valid[owner])
            o_req_ready[owner] = 1'b1;
      end
   end

   assign to_cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state      <= ST_IDLE;
         last_g     <= LAST_IDX;
         owner      <= '0;
         held_last  <= 1'b0;
         to_cnt     <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
         o_grant    <= '0;
         o_timeout  <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  owner      <= win;
                  o_tx_data  <= req_byte[win];
                  held_last  <= i_req_last[win];
                  o_grant    <= N_REQ'(1) << win;
                  o_tx_valid <= 1'b1;
                  state      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (i_tx_ready) begin
                  o_tx_valid <= 1'b0;
                  state      <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (held_last) begin
                  last_g  <= owner;
                  o_grant <= '0;
                  state   <= ST_IDLE;
               end else begin
                  to_cnt <= '0;
                  state  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // A byte arriving on the expiry cycle takes precedence over the timeout.
               if (i_req_valid[owner]) begin
                  o_tx_data  <= req_byte[owner];
                  held_last  <= i_req_last[owner];
                  o_tx_valid <= 1'b1;
                  state      <= ST_SEND;
               end else begin
                  to_cnt <= to_cnt_inc;
                  if (TIMEOUT_CYCLES != 0 && to_cnt_inc == TO_LIMIT) begin
                     o_timeout <= 1'b1;
                     last_g    <= owner;
                     o_grant   <= '0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
